// File: rtl/vga_arb_pkg.sv
// Shared types and constants for the VGA write-port arbiter.
// Also holds the round-robin successor helper.
package vga_arb_pkg;

    localparam int NREQ = 3;

    localparam logic [1:0] DRW_SCROLL = 2'd0;
    localparam logic [1:0] DRW_GAME   = 2'd1;
    localparam logic [1:0] DRW_ERR    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Next drawer in round-robin order; the unused code 3 folds back to drawer 0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            DRW_SCROLL: nxt = DRW_GAME;
            DRW_GAME:   nxt = DRW_ERR;
            default:    nxt = DRW_SCROLL;
        endcase
        return nxt;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
        logic [NREQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the drawer after 'last' gets first look,
// and 'last' itself is considered only when nobody else is requesting.
module rr_pick
    import vga_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic [1:0]      winner,
    output logic            any
);

    logic [1:0] first;
    logic [1:0] second;
    logic [1:0] third;

    always_comb begin
        first  = rr_next(last);
        second = rr_next(first);
        third  = rr_next(second);
        any    = |req;
        winner = first;
        if (req[first]) begin
            winner = first;
        end else if (req[second]) begin
            winner = second;
        end else if (req[third]) begin
            winner = third;
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Shares the single VGA adapter write port between three pixel drawers,
// granting whole bursts round-robin and revoking hung grants by timeout.
module vga_write_arbiter
    import vga_arb_pkg::*;
#(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COL_W   = 3,
    parameter int TIMEOUT = 19200,
    parameter int TO_W    = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     done,
    input  logic [NREQ*X_W-1:0] x_in,
    input  logic [NREQ*Y_W-1:0] y_in,
    input  logic [NREQ*COL_W-1:0] colour_in,
    input  logic [NREQ-1:0]     plot_in,
    output logic [NREQ-1:0]     gnt,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COL_W-1:0]    vga_colour,
    output logic                vga_plot,
    output logic                busy,
    output logic                timeout_err
);

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    arb_state_t      state;
    logic [1:0]      cur;
    logic [1:0]      last;
    logic [TO_W-1:0] cnt;

    logic [1:0] winner;
    logic       any_req;

    logic [X_W-1:0]   x_arr   [NREQ];
    logic [Y_W-1:0]   y_arr   [NREQ];
    logic [COL_W-1:0] col_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign x_arr[i]   = x_in[i*X_W +: X_W];
        assign y_arr[i]   = y_in[i*Y_W +: Y_W];
        assign col_arr[i] = colour_in[i*COL_W +: COL_W];
    end

    rr_pick u_pick (
        .req    (req),
        .last   (last),
        .winner (winner),
        .any    (any_req)
    );

    logic hit_done;
    logic hit_drop;
    logic hit_limit;
    logic leave;

    assign hit_done  = done[cur];
    assign hit_drop  = ~req[cur];
    assign hit_limit = (cnt == CNT_LAST);
    assign leave     = hit_done | hit_drop | hit_limit;

    // A timeout is only reported when the drawer is still asking and has not
    // just signalled its last pixel; done wins over a coincident timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cur         <= DRW_SCROLL;
            last        <= DRW_ERR;
            cnt         <= '0;
            gnt         <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    vga_plot    <= 1'b0;
                    timeout_err <= 1'b0;
                    if (any_req) begin
                        cur   <= winner;
                        gnt   <= onehot(winner);
                        cnt   <= '0;
                        state <= GRANT;
                        busy  <= 1'b1;
                    end
                end
                GRANT: begin
                    vga_x      <= x_arr[cur];
                    vga_y      <= y_arr[cur];
                    vga_colour <= col_arr[cur];
                    vga_plot   <= plot_in[cur];
                    if (leave) begin
                        state       <= RELEASE;
                        gnt         <= '0;
                        timeout_err <= hit_limit & ~hit_done & ~hit_drop;
                    end else begin
                        cnt <= cnt + TO_W'(1);
                    end
                end
                RELEASE: begin
                    gnt         <= '0;
                    vga_plot    <= 1'b0;
                    timeout_err <= 1'b0;
                    last        <= cur;
                    state       <= IDLE;
                    busy        <= 1'b0;
                end
                default: begin
                    gnt         <= '0;
                    vga_plot    <= 1'b0;
                    timeout_err <= 1'b0;
                    state       <= IDLE;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
